rptr_empty_lvl: RTL and testbench
=================================

// Module: rptr_empty_lvl
// PURPOSE
//  Read-domain pointer/flag block for the async FIFO, next generation of the read-pointer/empty logic.
//  Drives the FIFO RAM read address and the gray read pointer sent to the write domain.
//  Adds a registered fill level, a programmable almost-empty threshold and a sticky underflow flag.
//  Sits in rclk_i domain between the wptr 2-FF synchroniser (rq2_wptr_i) and the FIFO memory.
// PARAMETERS
//  ADDRSIZE   4   RAM address width; DEPTH = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits
// PORTS
//  rclk_i             in   1           read-domain clock
//  rrst_ni            in   1           reset, asynchronous, active-low
//  rq2_wptr_i         in   ADDRSIZE+1  gray write pointer, already synchronised into rclk_i
//  rinc_i             in   1           read request (pop one word this cycle)
//  r_ae_thresh_i      in   ADDRSIZE+1  almost-empty threshold, in words
//  r_underflow_clr_i  in   1           clear sticky underflow flag
//  raddr_o            out  ADDRSIZE    RAM read address
//  rptr_o             out  ADDRSIZE+1  registered gray read pointer, to write-domain sync
//  rempty_o           out  1           FIFO empty (registered)
//  r_almost_empty_o   out  1           level <= threshold (registered)
//  rlevel_o           out  ADDRSIZE+1  words available to read, 0..DEPTH (registered)
//  r_underflow_o      out  1           sticky: read attempted while empty
// BEHAVIOUR
//  Reset (async, rrst_ni=0): rbin=0, rptr_o=0, raddr_o=0, rempty_o=1, r_almost_empty_o=1,
//   rlevel_o=0, r_underflow_o=0. Outputs change immediately, without a clock edge.
//  Pointer: rd_ok = rinc_i & ~rempty_o; rbinnext = rbin + rd_ok; rgraynext = (rbinnext>>1)^rbinnext.
//   {rptr_o,rbin} <= {rgraynext,rbinnext} every rclk_i edge. raddr_o = rbin[ADDRSIZE-1:0] (from register).
//   Data for the pop is at raddr_o in the same cycle rinc_i is high (read-before-increment).
//  Level: wbin = gray2bin(rq2_wptr_i) (combinational XOR-prefix); level_next = (wbin - rbinnext)
//   modulo 2**(ADDRSIZE+1). rlevel_o <= level_next. Legal synchronised input guarantees level_next <= DEPTH.
//  Empty: rempty_o <= (rgraynext == rq2_wptr_i); always equal to (level_next == 0).
//  Almost empty: r_almost_empty_o <= (level_next <= r_ae_thresh_i), unsigned compare.
//   Threshold 0 -> identical to rempty_o; threshold >= DEPTH -> always 1. Threshold sampled every cycle,
//   so a change takes effect on the next edge.
//  Latency: a pop or a new rq2_wptr_i value is reflected in rempty_o/r_almost_empty_o/rlevel_o one rclk_i
//   edge later. Write progress is seen 2 wclk->rclk sync stages late: flags are pessimistic, never optimistic.
//  Underflow: rinc_i & rempty_o -> no pointer move, no address change, r_underflow_o <= 1 next edge.
//   r_underflow_clr_i alone -> r_underflow_o <= 0. Set and clear in the same cycle -> set wins.
//  Wrap: rbin/rptr_o wrap 2**(ADDRSIZE+1)-1 -> 0 naturally. The MSB distinguishes full from empty;
//   level subtraction is modular, so wrap is transparent. rptr_o changes by exactly one bit per pop.
//  Simultaneous pop and write-pointer advance in one cycle: level_next nets both (may stay unchanged).
//  No combinational path from any input to rptr_o, rempty_o, r_almost_empty_o, rlevel_o or r_underflow_o.
// TESTING (ADDRSIZE=4, DEPTH=16)
//  1 Reset: hold rrst_ni=0 -> rempty_o=1, r_almost_empty_o=1, rlevel_o=0, raddr_o=0, rptr_o=0, r_underflow_o=0.
//  2 Thresh=1, drive rq2_wptr_i=gray(3)=5'b00010 -> next edge: rempty_o=0, rlevel_o=3, r_almost_empty_o=0.
//    Pop 2 -> rlevel_o=1, r_almost_empty_o=1. Pop 1 -> rempty_o=1, rlevel_o=0, raddr_o=3.
//  3 Full: rbin=0, rq2_wptr_i=gray(16)=5'b11000 -> rlevel_o=16. 16 back-to-back pops: raddr_o=0..15,
//    rempty_o=1 on the edge after the 16th pop, rptr_o=5'b11000.
//  4 Underflow: rinc_i=1 while empty -> raddr_o/rptr_o unchanged, r_underflow_o=1. Clear and rinc_i
//    together while empty -> stays 1. Clear alone -> 0.
//  5 Wrap: stream 40 writes/pops with bench-modelled gray wptr across rbin 31->0 -> rlevel_o matches
//    the model every cycle, rptr_o Hamming distance <= 1 per edge, no spurious rempty_o.
//  6 Reset mid-operation: rlevel_o=5, rrst_ni low between edges -> all outputs at reset values at once.
//    Release -> the first pop is blocked until rq2_wptr_i advances.

Source files
------------

// File: rtl/rptr_empty_lvl.sv
`default_nettype none
// ============================================================================
// Module      : rptr_empty_lvl
// Description : Read-domain pointer and flag logic for an async FIFO.
//               Produces the RAM read address and the gray read pointer.
//               Also produces a registered fill level, a programmable
//               almost-empty flag and a sticky underflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rptr_empty_lvl #(
  parameter int ADDRSIZE = 4
) (
  input  logic                rclk_i,
  input  logic                rrst_ni,
  input  logic [ADDRSIZE:0]   rq2_wptr_i,
  input  logic                rinc_i,
  input  logic [ADDRSIZE:0]   r_ae_thresh_i,
  input  logic                r_underflow_clr_i,
  output logic [ADDRSIZE-1:0] raddr_o,
  output logic [ADDRSIZE:0]   rptr_o,
  output logic                rempty_o,
  output logic                r_almost_empty_o,
  output logic [ADDRSIZE:0]   rlevel_o,
  output logic                r_underflow_o
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] wbin;
  logic [PW-1:0] level_next;
  logic          rd_ok;

  // A pop only takes effect when the FIFO is not already flagged empty.
  assign rd_ok     = rinc_i & ~rempty_o;
  assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rd_ok};
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;

  // Gray to binary for the synchronised write pointer: each bit is the XOR
  // of itself and every more-significant gray bit.
  generate
    for (genvar i = 0; i < PW; i++) begin : g_gray2bin
      assign wbin[i] = ^rq2_wptr_i[PW-1:i];
    end
  endgenerate

  // Modular subtraction makes pointer wrap transparent.
  assign level_next = wbin - rbinnext;

  // The RAM address comes straight from the binary pointer register.
  assign raddr_o = rbin[ADDRSIZE-1:0];

  // Pointer, level and flag registers; everything updates on each edge.
  always_ff @(posedge rclk_i or negedge rrst_ni) begin
    if (!rrst_ni) begin
      rbin             <= '0;
      rptr_o           <= '0;
      rempty_o         <= 1'b1;
      r_almost_empty_o <= 1'b1;
      rlevel_o         <= '0;
    end else begin
      rbin             <= rbinnext;
      rptr_o           <= rgraynext;
      rempty_o         <= (rgraynext == rq2_wptr_i);
      r_almost_empty_o <= (level_next <= r_ae_thresh_i);
      rlevel_o         <= level_next;
    end
  end

  // Sticky underflow: a read attempted while empty sets it; set beats clear.
  always_ff @(posedge rclk_i or negedge rrst_ni) begin
    if (!rrst_ni) begin
      r_underflow_o <= 1'b0;
    end else if (rinc_i && rempty_o) begin
      r_underflow_o <= 1'b1;
    end else if (r_underflow_clr_i) begin
      r_underflow_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rptr_empty_lvl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rptr_empty_lvl
// Description : Directed self-checking bench for rptr_empty_lvl (ADDRSIZE=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rptr_empty_lvl;

  logic       rclk_i;
  logic       rrst_ni;
  logic [4:0] rq2_wptr_i;
  logic       rinc_i;
  logic [4:0] r_ae_thresh_i;
  logic       r_underflow_clr_i;
  logic [3:0] raddr_o;
  logic [4:0] rptr_o;
  logic       rempty_o;
  logic       r_almost_empty_o;
  logic [4:0] rlevel_o;
  logic       r_underflow_o;

  int checks;
  int passes;

  rptr_empty_lvl #(.ADDRSIZE(4)) dut (
    .rclk_i            (rclk_i),
    .rrst_ni           (rrst_ni),
    .rq2_wptr_i        (rq2_wptr_i),
    .rinc_i            (rinc_i),
    .r_ae_thresh_i     (r_ae_thresh_i),
    .r_underflow_clr_i (r_underflow_clr_i),
    .raddr_o           (raddr_o),
    .rptr_o            (rptr_o),
    .rempty_o          (rempty_o),
    .r_almost_empty_o  (r_almost_empty_o),
    .rlevel_o          (rlevel_o),
    .r_underflow_o     (r_underflow_o)
  );

  // 10 ns read clock.
  initial begin
    rclk_i = 1'b0;
    forever #5 rclk_i = ~rclk_i;
  end

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one edge and settle 1 ns after it.
  task automatic tick();
    @(posedge rclk_i);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_empty"}, rempty_o, 1);
    check({tag, "_ae"}, r_almost_empty_o, 1);
    check({tag, "_level"}, rlevel_o, 0);
    check({tag, "_raddr"}, raddr_o, 0);
    check({tag, "_rptr"}, rptr_o, 0);
    check({tag, "_uflow"}, r_underflow_o, 0);
  endtask

  task automatic do_reset();
    #2 rrst_ni = 1'b0;
    #1 rrst_ni = 1'b1;
    tick();
  endtask

  logic [4:0] wb, rb, lvl, prev_ptr;
  logic       m_empty, rd;

  initial begin
    checks = 0;
    passes = 0;
    rrst_ni           = 1'b1;
    rq2_wptr_i        = 5'd0;
    rinc_i            = 1'b0;
    r_ae_thresh_i     = 5'd1;
    r_underflow_clr_i = 1'b0;

    // 1: asynchronous reset, observed before any clock edge
    #1 rrst_ni = 1'b0;
    #1 check_reset_vals("rst");
    tick();
    rrst_ni = 1'b1;

    // 2: three words arrive, pop down through the threshold to empty
    rq2_wptr_i = 5'b00010;
    tick();
    check("t2_empty0", rempty_o, 0);
    check("t2_level3", rlevel_o, 3);
    check("t2_ae0", r_almost_empty_o, 0);
    rinc_i = 1'b1;
    tick();
    tick();
    rinc_i = 1'b0;
    check("t2_level1", rlevel_o, 1);
    check("t2_ae1", r_almost_empty_o, 1);
    check("t2_empty_l1", rempty_o, 0);
    check("t2_raddr2", raddr_o, 2);
    rinc_i = 1'b1;
    tick();
    rinc_i = 1'b0;
    check("t2_empty1", rempty_o, 1);
    check("t2_level0", rlevel_o, 0);
    check("t2_raddr3", raddr_o, 3);

    // 3: full FIFO drained by 16 back-to-back pops
    do_reset();
    rq2_wptr_i = 5'b11000;
    tick();
    check("t3_level16", rlevel_o, 16);
    check("t3_ae0", r_almost_empty_o, 0);
    rinc_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t3_raddr", raddr_o, i);
      check("t3_notempty", rempty_o, 0);
      tick();
    end
    rinc_i = 1'b0;
    check("t3_empty", rempty_o, 1);
    check("t3_rptr", rptr_o, 5'b11000);
    check("t3_level0", rlevel_o, 0);

    // 4: underflow set, set-beats-clear, then clear alone
    rinc_i = 1'b1;
    tick();
    check("t4_raddr", raddr_o, 0);
    check("t4_rptr", rptr_o, 5'b11000);
    check("t4_uflow_set", r_underflow_o, 1);
    r_underflow_clr_i = 1'b1;
    tick();
    check("t4_uflow_setwins", r_underflow_o, 1);
    rinc_i = 1'b0;
    tick();
    r_underflow_clr_i = 1'b0;
    check("t4_uflow_clr", r_underflow_o, 0);

    // 5: streamed writes and pops across the 31->0 pointer wrap
    rb = 5'd16;
    wb = 5'd16;
    m_empty = 1'b1;
    prev_ptr = rptr_o;
    for (int i = 0; i < 40; i++) begin
      if ((i % 3) != 2 && (5'(wb - rb) < 5'd15)) wb = wb + 5'd1;
      rq2_wptr_i = gray(wb);
      rinc_i = ((i % 4) != 3);
      rd = rinc_i & ~m_empty;
      rb = rb + {4'd0, rd};
      lvl = wb - rb;
      m_empty = (lvl == 5'd0);
      tick();
      check("t5_level", rlevel_o, lvl);
      check("t5_empty", rempty_o, m_empty);
      check("t5_rptr", rptr_o, gray(rb));
      check("t5_hamming", int'($countones(prev_ptr ^ rptr_o) <= 1), 1);
      prev_ptr = rptr_o;
    end
    rinc_i = 1'b0;
    check("t5_wrapped", int'(rb < 5'd16), 1);

    // 6: asynchronous reset in the middle of operation
    do_reset();
    rq2_wptr_i = 5'b00111;
    tick();
    check("t6_level5", rlevel_o, 5);
    #2 rrst_ni = 1'b0;
    #1 check_reset_vals("t6rst");
    rq2_wptr_i = 5'd0;
    tick();
    rrst_ni = 1'b1;
    rinc_i = 1'b1;
    tick();
    check("t6_blk_raddr", raddr_o, 0);
    check("t6_blk_rptr", rptr_o, 0);
    check("t6_blk_empty", rempty_o, 1);
    rq2_wptr_i = 5'b00011;
    tick();
    check("t6_adv_raddr", raddr_o, 0);
    check("t6_adv_level", rlevel_o, 2);
    tick();
    check("t6_pop_raddr", raddr_o, 1);
    check("t6_pop_level", rlevel_o, 1);
    rinc_i = 1'b0;

    // Threshold at DEPTH keeps almost-empty asserted while not empty.
    r_ae_thresh_i = 5'd16;
    tick();
    check("ae_thresh16", r_almost_empty_o, 1);
    r_ae_thresh_i = 5'd0;
    tick();
    check("ae_thresh0", r_almost_empty_o, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
